// File: rtl/cpu_irq_wdog.sv
// Raster IRQ generator, frame watchdog and CPU reset sequencer for the p6502 wrapper.
// All outputs registered (one clk from cause to effect); no backpressure, bus writes are snooped only.
module cpu_irq_wdog #(
    parameter int          IRQ_FIRST    = 16,
    parameter int          IRQ_SPACING  = 64,
    parameter logic [15:0] IRQ_ACK_ADDR = 16'h2600,
    parameter logic [15:0] WDOG_ADDR    = 16'h2500,
    parameter int          WDOG_FRAMES  = 8,
    parameter int          RESET_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_ce,
    input  logic [15:0] cpu_a,
    input  logic        cpu_rw_n,
    input  logic [7:0]  vcount,
    input  logic        vblank,
    input  logic        wdog_en,
    output logic        irq_n,
    output logic        cpu_reset_n,
    output logic        wdog_fired
);
    localparam logic [7:0] FIRST_LINE   = 8'(IRQ_FIRST);
    localparam logic [7:0] SPACING_MASK = 8'(IRQ_SPACING - 1);
    localparam logic [7:0] WDOG_LIMIT   = 8'(WDOG_FRAMES);
    localparam logic [7:0] HOLD_LEN     = 8'(RESET_CYCLES);

    typedef enum logic {HOLD, RUN} state_t;

    state_t     state;
    logic [7:0] hold_cnt;
    logic [7:0] wdog_cnt;
    logic [7:0] vcount_prev;
    logic       vblank_prev;

    logic       bus_wr;
    logic       ack;
    logic       kick;
    logic [7:0] line_ofs;
    logic       raise;
    logic       vblank_rise;
    logic       expire;

    assign bus_wr      = cpu_ce && !cpu_rw_n;
    assign ack         = bus_wr && (cpu_a == IRQ_ACK_ADDR);
    assign kick        = bus_wr && (cpu_a == WDOG_ADDR);
    // Spacing is a power of two, so the modulo reduces to a mask of the line offset.
    assign line_ofs    = vcount - FIRST_LINE;
    assign raise       = (vcount != vcount_prev) && (vcount >= FIRST_LINE)
                         && ((line_ofs & SPACING_MASK) == 8'd0);
    assign vblank_rise = vblank && !vblank_prev;
    assign expire      = vblank_rise && wdog_en && !kick && ((wdog_cnt + 8'd1) == WDOG_LIMIT);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= HOLD;
            hold_cnt    <= HOLD_LEN;
            wdog_cnt    <= 8'd0;
            vcount_prev <= vcount;
            vblank_prev <= 1'b1;
            irq_n       <= 1'b1;
            cpu_reset_n <= 1'b0;
            wdog_fired  <= 1'b0;
        end else begin
            vcount_prev <= vcount;
            vblank_prev <= vblank;
            wdog_fired  <= 1'b0;
            case (state)
                HOLD: begin
                    irq_n       <= 1'b1;
                    wdog_cnt    <= 8'd0;
                    cpu_reset_n <= 1'b0;
                    hold_cnt    <= hold_cnt - 8'd1;
                    if (hold_cnt == 8'd1) begin
                        state       <= RUN;
                        cpu_reset_n <= 1'b1;
                    end
                end
                RUN: begin
                    if (expire) begin
                        state       <= HOLD;
                        hold_cnt    <= HOLD_LEN;
                        wdog_cnt    <= 8'd0;
                        irq_n       <= 1'b1;
                        cpu_reset_n <= 1'b0;
                        wdog_fired  <= 1'b1;
                    end else begin
                        // A raster line landing on the same clk as an ack re-arms the irq.
                        if (raise)
                            irq_n <= 1'b0;
                        else if (ack)
                            irq_n <= 1'b1;

                        if (kick || !wdog_en)
                            wdog_cnt <= 8'd0;
                        else if (vblank_rise)
                            wdog_cnt <= wdog_cnt + 8'd1;
                    end
                end
                default: begin
                    state       <= HOLD;
                    hold_cnt    <= HOLD_LEN;
                    cpu_reset_n <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_irq_wdog.sv
// Directed plus randomized bench for cpu_irq_wdog against a cycle-level behavioural model.
module tb_cpu_irq_wdog;
    localparam logic [15:0] ACK_A  = 16'h2600;
    localparam logic [15:0] WDOG_A = 16'h2500;
    localparam int HOLD_N   = 32;
    localparam int FRAMES_N = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_ce;
    logic [15:0] cpu_a;
    logic        cpu_rw_n;
    logic [7:0]  vcount;
    logic        vblank;
    logic        wdog_en;
    logic        irq_n;
    logic        cpu_reset_n;
    logic        wdog_fired;

    int checks = 0;
    int errors = 0;
    int fires  = 0;
    int falls  = 0;

    // Behavioural model: cycles of reset left, irq pending flag, frames since last kick.
    int m_hold;
    bit m_irq;
    int m_frames;
    bit m_fired;
    int m_prev_v;
    bit m_prev_vb;

    cpu_irq_wdog dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cpu_ce      (cpu_ce),
        .cpu_a       (cpu_a),
        .cpu_rw_n    (cpu_rw_n),
        .vcount      (vcount),
        .vblank      (vblank),
        .wdog_en     (wdog_en),
        .irq_n       (irq_n),
        .cpu_reset_n (cpu_reset_n),
        .wdog_fired  (wdog_fired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int  v;
        bit  line_hit;
        bit  wr;
        v        = int'(vcount);
        line_hit = (v != m_prev_v) && (v >= 16) && (((v - 16) % 64) == 0);
        wr       = cpu_ce && !cpu_rw_n;
        m_fired  = 1'b0;
        if (!reset_n) begin
            m_hold   = HOLD_N;
            m_irq    = 1'b0;
            m_frames = 0;
            m_prev_v = v;
            m_prev_vb = 1'b1;
            return;
        end
        if (m_hold > 0) begin
            m_hold--;
        end else begin
            if (wr && cpu_a == WDOG_A)
                m_frames = 0;
            else if (!wdog_en)
                m_frames = 0;
            else if (vblank && !m_prev_vb) begin
                m_frames++;
                if (m_frames == FRAMES_N) begin
                    m_fired  = 1'b1;
                    m_hold   = HOLD_N;
                    m_irq    = 1'b0;
                    m_frames = 0;
                end
            end
            if (!m_fired) begin
                if (line_hit)
                    m_irq = 1'b1;
                else if (wr && cpu_a == ACK_A)
                    m_irq = 1'b0;
            end
        end
        m_prev_v  = v;
        m_prev_vb = vblank;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("cpu_reset_n", cpu_reset_n, m_hold == 0);
        chk("irq_n", irq_n, !m_irq);
        chk("wdog_fired", wdog_fired, m_fired);
        if (wdog_fired === 1'b1) fires++;
    endtask

    task automatic idle();
        cpu_ce   = 1'b0;
        cpu_rw_n = 1'b1;
        cpu_a    = 16'h0000;
    endtask

    task automatic set_wr(input logic [15:0] addr);
        cpu_ce   = 1'b1;
        cpu_rw_n = 1'b0;
        cpu_a    = addr;
    endtask

    task automatic wr(input logic [15:0] addr);
        set_wr(addr);
        tick();
        idle();
    endtask

    task automatic frame(input bit kick_edge, input bit kick_after);
        vblank = 1'b0;
        repeat (8) tick();
        vblank = 1'b1;
        if (kick_edge) set_wr(WDOG_A);
        tick();
        idle();
        if (kick_after) set_wr(WDOG_A);
        tick();
        idle();
        tick();
    endtask

    task automatic hold_check(input string tag);
        for (int i = 0; i < HOLD_N - 1; i++) begin
            tick();
            chk({tag, "_low"}, cpu_reset_n, 1'b0);
            chk({tag, "_irq"}, irq_n, 1'b1);
        end
        tick();
        chk({tag, "_high"}, cpu_reset_n, 1'b1);
    endtask

    initial begin
        reset_n = 1'b0;
        vcount  = 8'd0;
        vblank  = 1'b0;
        wdog_en = 1'b0;
        idle();

        // Power-up reset and 32-clk hold.
        repeat (4) tick();
        chk("rst_cpu_reset_n", cpu_reset_n, 1'b0);
        chk("rst_irq_n", irq_n, 1'b1);
        chk("rst_wdog_fired", wdog_fired, 1'b0);
        reset_n = 1'b1;
        hold_check("powerup");

        // Raster sweep with ack ten clks after every irq.
        for (int v = 0; v < 256; v++) begin
            vcount = 8'(v);
            tick();
            chk("irq_line", irq_n, !((v >= 16) && (((v - 16) % 64) == 0)));
            if (irq_n === 1'b0) begin
                falls++;
                repeat (9) tick();
                wr(ACK_A);
                chk("irq_acked", irq_n, 1'b1);
            end
        end
        chk("irq_fall_count", falls, 4);

        // Ack on the same clk as a raise loses; strobe-less writes and reads do nothing.
        vcount = 8'd79;
        tick();
        vcount = 8'd80;
        set_wr(ACK_A);
        tick();
        idle();
        chk("ack_vs_raise", irq_n, 1'b0);
        cpu_a = ACK_A; cpu_rw_n = 1'b0; cpu_ce = 1'b0;
        repeat (2) tick();
        chk("ack_no_ce", irq_n, 1'b0);
        cpu_a = ACK_A; cpu_rw_n = 1'b1; cpu_ce = 1'b1;
        tick();
        idle();
        chk("ack_read", irq_n, 1'b0);
        wr(ACK_A);
        chk("ack_late", irq_n, 1'b1);

        // Unkicked watchdog fires on the 8th vblank edge.
        wdog_en = 1'b1;
        fires = 0;
        repeat (7) frame(1'b0, 1'b0);
        chk("wdog_pre_fire", fires, 0);
        vblank = 1'b0;
        repeat (8) tick();
        vblank = 1'b1;
        tick();
        chk("wdog_fire_pulse", wdog_fired, 1'b1);
        chk("wdog_fire_rst", cpu_reset_n, 1'b0);
        hold_check("wdog_hold");
        chk("wdog_fire_once", fires, 1);
        vblank = 1'b0;

        // Regular kicks keep it quiet; a kick on an edge clears the count.
        fires = 0;
        for (int i = 1; i <= 50; i++) frame(1'b0, (i % 7) == 0);
        chk("kick_no_fire", fires, 0);
        wr(WDOG_A);
        repeat (7) frame(1'b0, 1'b0);
        frame(1'b1, 1'b0);
        repeat (7) frame(1'b0, 1'b0);
        chk("kick_on_edge", fires, 0);
        frame(1'b0, 1'b0);
        chk("kick_then_fire", fires, 1);
        repeat (40) tick();

        // Disabled watchdog, then a full unkicked run; reset mid-hold restarts it.
        wdog_en = 1'b0;
        fires = 0;
        repeat (20) frame(1'b0, 1'b0);
        chk("dis_no_fire", fires, 0);
        wdog_en = 1'b1;
        repeat (7) frame(1'b0, 1'b0);
        chk("en_pre_fire", fires, 0);
        vblank = 1'b0;
        repeat (8) tick();
        vblank = 1'b1;
        tick();
        chk("en_fire", wdog_fired, 1'b1);
        repeat (10) tick();
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        hold_check("midhold");
        vblank = 1'b0;

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            int sel;
            reset_n = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 3) == 0) vcount = vcount + 8'd1;
            else if ($urandom_range(0, 49) == 0) vcount = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) vblank = ~vblank;
            wdog_en  = ($urandom_range(0, 9) != 0);
            cpu_ce   = ($urandom_range(0, 2) == 0);
            cpu_rw_n = ($urandom_range(0, 3) == 0);
            sel      = $urandom_range(0, 2);
            cpu_a    = (sel == 0) ? WDOG_A : (sel == 1) ? ACK_A : 16'($urandom_range(0, 65535));
            tick();
        end
        idle();
        reset_n = 1'b1;
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
